tanh_exp_post: RTL and testbench

TANH_EXP_POST -- requirements
Module: tanh_exp_post

---
 rtl/sinh_cosh_pkg.sv | 12 +
 rtl/hyp_div_serial.sv | 61 ++++++
 rtl/tanh_exp_post.sv | 106 ++++++++++
 tb/tb_tanh_exp_post.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sinh_cosh_pkg.sv
// Shared types and constants for the sinh/cosh post-processing block.
// All data words are Q2.14 two's complement unless noted otherwise.
package sinh_cosh_pkg;
  localparam int DW    = 16;
  localparam int FRAC  = 14;
  localparam int ITERS = 16;

  localparam logic [15:0] ONE      = 16'h4000;
  localparam logic [15:0] TANH_MAX = 16'h3FFF;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/hyp_div_serial.sv
// Unsigned restoring divider, one quotient bit per cycle over ITERS cycles.
// Upper dividend bits seed the remainder; q_ovf flags a quotient that cannot fit in ITERS bits.
module hyp_div_serial #(
  parameter int DW   = 16,
  parameter int FRAC = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DW+FRAC-1:0] dividend,
  input  logic [DW-1:0]      divisor,
  output logic               busy,
  output logic               done,
  output logic [DW-1:0]      quotient,
  output logic               q_ovf
);
  import sinh_cosh_pkg::*;

  localparam int NW = DW + FRAC;
  localparam int CW = $clog2(ITERS + 1);

  logic [DW-1:0]       rem;
  logic [DW-1:0]       dvs;
  logic [DW:0]         trial;
  logic [ITERS-1:0]    qsh;
  logic [CW-1:0]       cnt;
  logic                qbit;
  logic [NW-ITERS-1:0] hi;

  assign hi       = dividend[NW-1:ITERS];
  assign trial    = {rem, qsh[ITERS-1]};
  assign qbit     = trial >= {1'b0, dvs};
  assign busy     = cnt != '0;
  assign quotient = DW'(qsh);

  // qsh holds the unconsumed low dividend bits and collects quotient bits from the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      dvs   <= '0;
      qsh   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      q_ovf <= 1'b0;
    end else if (start) begin
      rem   <= DW'(hi);
      dvs   <= divisor;
      qsh   <= dividend[ITERS-1:0];
      cnt   <= CW'(ITERS);
      done  <= 1'b0;
      q_ovf <= DW'(hi) >= divisor;
    end else if (busy) begin
      rem  <= qbit ? DW'(trial - {1'b0, dvs}) : trial[DW-1:0];
      qsh  <= {qsh[ITERS-2:0], qbit};
      cnt  <= cnt - 1'b1;
      done <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/tanh_exp_post.sv
// CORDIC post-stage: tanh = sinh/cosh via a serial divider, e^x and e^-x as sum/difference.
// A one-entry hold register absorbs a sample arriving while the core is busy.
module tanh_exp_post #(
  parameter int DW   = sinh_cosh_pkg::DW,
  parameter int FRAC = sinh_cosh_pkg::FRAC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sinh,
  input  logic [DW-1:0] cosh,
  input  logic          sinh_cosh_tvalid,
  output logic [DW-1:0] tanh,
  output logic [DW:0]   exp_pos,
  output logic [DW:0]   exp_neg,
  output logic          out_tvalid,
  input  logic          out_tready,
  output logic          div_err,
  output logic          ovf
);
  import sinh_cosh_pkg::*;

  state_t        state, state_nx;
  logic          hold_vld;
  logic [DW-1:0] hold_sinh, hold_cosh;
  logic          cap_en, cap_err;
  logic [DW-1:0] cap_sinh, cap_cosh, cap_mag;
  logic          cur_neg;
  logic          div_start, div_busy, div_done, div_ovf;
  logic [DW-1:0] div_q, q_sat;

  assign out_tvalid = (state == DONE);

  // A held sample is always older than one on the input, so it goes first
  always_comb begin
    cap_sinh  = hold_vld ? hold_sinh : sinh;
    cap_cosh  = hold_vld ? hold_cosh : cosh;
    cap_en    = (hold_vld || sinh_cosh_tvalid) &&
                (state == IDLE || (state == DONE && out_tready));
    cap_err   = cap_cosh[DW-1] || (cap_cosh == '0);
    cap_mag   = cap_sinh[DW-1] ? -cap_sinh : cap_sinh;
    div_start = cap_en && !cap_err;
    q_sat     = (div_ovf || div_q > DW'(TANH_MAX)) ? DW'(TANH_MAX) : div_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cap_en) state_nx = DIV;
      DIV:     if (div_err || (div_done && !div_busy)) state_nx = DONE;
      DONE:    if (out_tready) state_nx = cap_en ? DIV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_vld  <= 1'b0;
      hold_sinh <= '0;
      hold_cosh <= '0;
      tanh      <= '0;
      exp_pos   <= '0;
      exp_neg   <= '0;
      div_err   <= 1'b0;
      cur_neg   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap_en) begin
        exp_pos <= {cap_sinh[DW-1], cap_sinh} + {cap_cosh[DW-1], cap_cosh};
        exp_neg <= {cap_cosh[DW-1], cap_cosh} - {cap_sinh[DW-1], cap_sinh};
        div_err <= cap_err;
        cur_neg <= cap_sinh[DW-1];
        tanh    <= '0;
      end
      if (state == DIV && !div_err && div_done)
        tanh <= cur_neg ? -q_sat : q_sat;
      // Draining and refilling the hold in the same cycle never loses a sample
      if (cap_en && hold_vld) begin
        hold_vld  <= sinh_cosh_tvalid;
        hold_sinh <= sinh;
        hold_cosh <= cosh;
      end else if (!cap_en && sinh_cosh_tvalid) begin
        if (!hold_vld) begin
          hold_vld  <= 1'b1;
          hold_sinh <= sinh;
          hold_cosh <= cosh;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

  hyp_div_serial #(.DW(DW), .FRAC(FRAC)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend ({cap_mag, {FRAC{1'b0}}}),
    .divisor  (cap_cosh),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q),
    .q_ovf    (div_ovf)
  );
endmodule

// File: tb/tb_tanh_exp_post.sv
// Self-checking bench for tanh_exp_post against an arithmetic reference model.
module tb_tanh_exp_post;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sinh, cosh;
  logic        tv;
  logic [15:0] tanh;
  logic [16:0] exp_pos, exp_neg;
  logic        out_tvalid, out_tready, div_err, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tanh_exp_post #(.DW(16), .FRAC(14)) dut (
    .clk(clk), .rst(rst), .sinh(sinh), .cosh(cosh), .sinh_cosh_tvalid(tv),
    .tanh(tanh), .exp_pos(exp_pos), .exp_neg(exp_neg), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .div_err(div_err), .ovf(ovf)
  );

  // Expected {tanh, exp_pos, exp_neg, div_err} from plain integer arithmetic
  function automatic logic [50:0] model(input logic [15:0] s, input logic [15:0] c);
    int si, ci;
    longint q;
    logic [15:0] t;
    logic [16:0] ep, en;
    logic e;
    si = int'($signed(s));
    ci = int'($signed(c));
    ep = 17'(si + ci);
    en = 17'(ci - si);
    if (ci <= 0) begin
      t = '0;
      e = 1'b1;
    end else begin
      q = longint'(si < 0 ? -si : si) * 16384;
      q = q / ci;
      if (q > 16383) q = 16383;
      t = (si < 0) ? 16'(-q) : 16'(q);
      e = 1'b0;
    end
    return {t, ep, en, e};
  endfunction

  task automatic send(input logic [15:0] s, input logic [15:0] c);
    sinh = s; cosh = c; tv = 1'b1;
    @(posedge clk); #1;
    tv = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_tvalid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; out_tready = 1'b0;
    tv = 1'b1; sinh = 16'h1000; cosh = 16'h4000;
    repeat (2) @(posedge clk);
    #1;
    tv = 1'b0; rst = 1'b0;
    n_checks++;
    if ({out_tvalid, ovf, div_err, tanh, exp_pos, exp_neg} !== 54'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b ovf=%b err=%b tanh=%h ep=%h en=%h, want all 0",
               out_tvalid, ovf, div_err, tanh, exp_pos, exp_neg);
    end
    repeat (25) @(posedge clk);
    #1;
    n_checks++;
    if (out_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: out_tvalid=%b, want 0", out_tvalid);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ds [0:6];
    logic [15:0] dc [0:6];
    logic [50:0] exp_v;
    int lat;
    ds = '{16'h0000, 16'hE000, 16'h3700, 16'h1234, 16'h8000, 16'h4000, 16'h2000};
    dc = '{16'h4000, 16'h4000, 16'h54C6, 16'h0000, 16'h4000, 16'h4000, 16'hC000};
    for (int i = 0; i < 7; i++) begin
      exp_v = model(ds[i], dc[i]);
      send(ds[i], dc[i]);
      wait_valid(lat);
      n_checks++;
      if (lat !== (exp_v[0] ? 1 : 17)) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: got %0d edges, want %0d", i, lat, exp_v[0] ? 1 : 17);
      end
      n_checks++;
      if ({tanh, exp_pos, exp_neg, div_err} !== exp_v) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got %h/%h/%h/%b want %h/%h/%h/%b", i,
                 tanh, exp_pos, exp_neg, div_err, exp_v[50:35], exp_v[34:18], exp_v[17:1], exp_v[0]);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({out_tvalid, tanh, exp_pos, exp_neg, div_err} !== {1'b1, exp_v}) begin
        n_fail++;
        $display("FAIL dir_hold[%0d]: v=%b tanh=%h ep=%h en=%h err=%b", i,
                 out_tvalid, tanh, exp_pos, exp_neg, div_err);
      end
      out_tready = 1'b1;
      @(posedge clk); #1;
      out_tready = 1'b0;
      n_checks++;
      if (out_tvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_accept[%0d]: out_tvalid=%b after handshake, want 0", i, out_tvalid);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] s, c;
    logic [50:0] exp_v;
    int lat;
    for (int i = 0; i < 16; i++) begin
      s = 16'($urandom);
      c = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(1, 32767));
      exp_v = model(s, c);
      send(s, c);
      wait_valid(lat);
      n_checks++;
      if (lat !== (exp_v[0] ? 1 : 17) || {tanh, exp_pos, exp_neg, div_err} !== exp_v) begin
        n_fail++;
        $display("FAIL rand[%0d] s=%h c=%h: lat=%0d got %h/%h/%h/%b want %h/%h/%h/%b", i, s, c, lat,
                 tanh, exp_pos, exp_neg, div_err, exp_v[50:35], exp_v[34:18], exp_v[17:1], exp_v[0]);
      end
      out_tready = 1'b1;
      @(posedge clk); #1;
      out_tready = 1'b0;
    end
  endtask

  task automatic test_overflow;
    logic [15:0] s [0:2];
    logic [15:0] c [0:2];
    int lat, extra;
    for (int i = 0; i < 3; i++) begin
      s[i] = 16'($urandom);
      c[i] = 16'($urandom_range(1, 32767));
    end
    out_tready = 1'b0;
    tv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sinh = s[i]; cosh = c[i];
      @(posedge clk); #1;
    end
    tv = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b, want 1", ovf);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 15 || {tanh, exp_pos, exp_neg, div_err} !== model(s[0], c[0])) begin
      n_fail++;
      $display("FAIL ovf_first: lat=%0d tanh=%h ep=%h, want lat=15 %h", lat, tanh, exp_pos,
               model(s[0], c[0]));
    end
    out_tready = 1'b1;
    @(posedge clk); #1;
    wait_valid(lat);
    n_checks++;
    if (lat !== 17 || {tanh, exp_pos, exp_neg, div_err} !== model(s[1], c[1])) begin
      n_fail++;
      $display("FAIL ovf_second: lat=%0d tanh=%h ep=%h, want lat=17 %h", lat, tanh, exp_pos,
               model(s[1], c[1]));
    end
    @(posedge clk); #1;
    extra = 0;
    repeat (30) begin
      if (out_tvalid) extra++;
      @(posedge clk); #1;
    end
    out_tready = 1'b0;
    n_checks++;
    if (extra !== 0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: extra valid cycles=%0d ovf=%b, want 0 and 1", extra, ovf);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b after reset, want 0", ovf);
    end
  endtask

  task automatic test_back_to_back;
    logic [50:0] expq[$];
    int tq[$];
    logic [50:0] e;
    logic [15:0] s, c;
    out_tready = 1'b1;
    for (int cyc = 0; cyc < 75; cyc++) begin
      tv = (cyc == 0 || cyc == 1 || cyc == 18);
      if (tv) begin
        s = 16'($urandom);
        c = 16'($urandom_range(1, 32767));
        sinh = s; cosh = c;
        expq.push_back(model(s, c));
      end
      if (out_tvalid) begin
        tq.push_back(cyc);
        n_checks++;
        e = (expq.size() > 0) ? expq.pop_front() : '1;
        if ({tanh, exp_pos, exp_neg, div_err} !== e) begin
          n_fail++;
          $display("FAIL b2b_result@%0d: got %h/%h/%h/%b want %h", cyc,
                   tanh, exp_pos, exp_neg, div_err, e);
        end
      end
      @(posedge clk); #1;
    end
    tv = 1'b0;
    out_tready = 1'b0;
    n_checks++;
    if (tq.size() !== 3 || tq[0] !== 18 || tq[1] !== 36 || tq[2] !== 54 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_timing: %0d results at %p ovf=%b, want 3 at 18,36,54 ovf=0",
               tq.size(), tq, ovf);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] s, c;
    int lat, bad;
    out_tready = 1'b0;
    send(16'h2345, 16'h3000);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({out_tvalid, ovf, div_err, tanh, exp_pos, exp_neg} !== 54'd0) begin
      n_fail++;
      $display("FAIL midrst_state: v=%b tanh=%h ep=%h en=%h err=%b, want all 0",
               out_tvalid, tanh, exp_pos, exp_neg, div_err);
    end
    bad = 0;
    repeat (30) begin
      if (out_tvalid) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrst_novalid: %0d valid cycles, want 0", bad);
    end
    s = 16'hC800; c = 16'h5000;
    send(s, c);
    wait_valid(lat);
    n_checks++;
    if (lat !== 17 || {tanh, exp_pos, exp_neg, div_err} !== model(s, c)) begin
      n_fail++;
      $display("FAIL midrst_next: lat=%0d tanh=%h ep=%h en=%h, want lat=17 %h",
               lat, tanh, exp_pos, exp_neg, model(s, c));
    end
    out_tready = 1'b1;
    @(posedge clk); #1;
    out_tready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tv = 1'b0; sinh = '0; cosh = '0; out_tready = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
